// File: rtl/fracnet_mul_pkg.sv
// ---------------------------------------------------------------------------
// fracnet_mul_pkg
// Shared constants and types for the shared-multiplier arbiter slice.
//   MUL_A_W / MUL_B_W / MUL_P_W : operand and product widths of the external
//                                 16s x 8u multiplier.
//   MUL_LAT                     : register depth of that multiplier.
//   mul_tag_t                   : {valid, id} record travelling beside the
//                                 multiplier data; id is sized for up to
//                                 eight requesters.
// ---------------------------------------------------------------------------
package fracnet_mul_pkg;

    localparam int MUL_A_W      = 32'sd16;
    localparam int MUL_B_W      = 32'sd8;
    localparam int MUL_P_W      = 32'sd24;
    localparam int MUL_LAT      = 32'sd3;
    localparam int MUL_ID_W_MAX = 32'sd3;

    typedef struct packed {
        logic                    valid;
        logic [MUL_ID_W_MAX-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/fracnet_mul_share_arb_if.sv
// ---------------------------------------------------------------------------
// fracnet_mul_share_arb_if
// Requester and result handshake bundle of the shared multiplier.
//   req_valid/req_a/req_b/req_ready : N_REQ operand channels (slice i = req i)
//   res_valid/res_ready/res_data/res_id : single result channel
// Modports: master = requesters + result consumer, slave = arbiter block.
// ---------------------------------------------------------------------------
interface fracnet_mul_share_arb_if
    import fracnet_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);

    logic [N_REQ-1:0]         req_valid;
    logic [MUL_A_W*N_REQ-1:0] req_a;
    logic [MUL_B_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]         req_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [MUL_P_W-1:0]       res_data;
    logic [ID_W-1:0]          res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );

endinterface

// File: rtl/fracnet_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fracnet_rr_arbiter
// N-way round-robin arbiter with its rotating priority pointer.
//   clk, reset (sync, active-low)
//   en        : grants allowed this cycle (pipe not stalled, not in reset)
//   req_valid : request vector
//   grant     : one-hot grant, zero when nothing is granted
//   grant_idx : encoded index of the winner
//   grant_any : a grant is issued this cycle
// ---------------------------------------------------------------------------
module fracnet_rr_arbiter
    import fracnet_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cand_s;
    logic [ID_W-1:0] idx_s;
    logic [ID_W-1:0] ptr_next_s;
    logic            found_s;
    logic            take_s;

    // Index arithmetic modulo N_REQ (N_REQ need not be a power of two).
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W:0] v);
        logic [ID_W:0] w;
        if (v >= (ID_W + 1)'(N_REQ)) begin
            w = v - (ID_W + 1)'(N_REQ);
        end else begin
            w = v;
        end
        return w[ID_W-1:0];
    endfunction

    // Scan requests starting at rr_ptr; the first valid one wins.
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        cand_s  = '0;
        take_s  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s  = wrap_idx({1'b0, rr_ptr} + (ID_W + 1)'(k));
            take_s  = ~found_s & req_valid[cand_s];
            idx_s   = take_s ? cand_s : idx_s;
            found_s = found_s | take_s;
        end
    end

    assign grant_any = found_s & en;
    assign grant_idx = idx_s;

    // One-hot decode of the winner.
    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant[idx_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign ptr_next_s = (idx_s == ID_W'(N_REQ - 1)) ? '0 : idx_s + ID_W'(1);

    // Priority pointer moves just past the last winner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= ptr_next_s;
        end else begin
            rr_ptr <= rr_ptr;
        end
    end

endmodule

// File: rtl/fracnet_mul_share_arb.sv
// ---------------------------------------------------------------------------
// fracnet_mul_share_arb
// Shares one external pipelined 16s x 8u multiplier among N_REQ requesters.
//   clk, reset  : clock, synchronous active-low reset
//   bus (slave) : requester channels and the valid/ready result channel
//   mul_ce      : multiplier clock enable, low while a result is back-pressured
//   mul_din0/1  : operands to the multiplier
//   mul_dout    : product from the multiplier (MUL_LAT edges later)
//   inflight    : number of valid entries in the tag pipeline
// A {valid,id} tag pipeline, clocked by the same ce as the multiplier,
// marks which multiplier stages carry real products.
// ---------------------------------------------------------------------------
module fracnet_mul_share_arb
    import fracnet_mul_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int MUL_LAT = fracnet_mul_pkg::MUL_LAT,
    parameter  int ID_W    = $clog2(N_REQ),
    localparam int INF_W   = $clog2(MUL_LAT + 1) + 1
)
(
    input  logic                 clk,
    input  logic                 reset,
    fracnet_mul_share_arb_if.slave bus,
    output logic                 mul_ce,
    output logic [MUL_A_W-1:0]   mul_din0,
    output logic [MUL_B_W-1:0]   mul_din1,
    input  logic [MUL_P_W-1:0]   mul_dout,
    output logic [INF_W-1:0]     inflight
);

    logic [N_REQ-1:0]   grant_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic               grant_any_s;
    logic               en_s;
    logic               consume_s;
    logic [MUL_A_W-1:0] a_last_r;
    logic [MUL_B_W-1:0] b_last_r;
    mul_tag_t           tag_r [MUL_LAT];

    // A back-pressured valid tail freezes the multiplier and the tag pipe;
    // an invalid tail never stalls, so bubbles drain out.
    assign mul_ce = ~(bus.res_valid & ~bus.res_ready);

    // No grants while reset is asserted, so no handshake is lost to reset.
    assign en_s = mul_ce & reset;

    fracnet_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (en_s),
        .req_valid (bus.req_valid),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    assign bus.req_ready = grant_s;

    // Operand mux: winner's operands, else the last issued pair.
    always_comb begin
        if (grant_any_s) begin
            mul_din0 = bus.req_a[grant_idx_s * MUL_A_W +: MUL_A_W];
            mul_din1 = bus.req_b[grant_idx_s * MUL_B_W +: MUL_B_W];
        end else begin
            mul_din0 = a_last_r;
            mul_din1 = b_last_r;
        end
    end

    // Remember the last issued operand pair for the idle mux path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_last_r <= '0;
            b_last_r <= '0;
        end else if (grant_any_s) begin
            a_last_r <= mul_din0;
            b_last_r <= mul_din1;
        end else begin
            a_last_r <= a_last_r;
            b_last_r <= b_last_r;
        end
    end

    // Tag pipeline, advancing in lock-step with the multiplier's ce.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_r[s] <= '0;
            end
        end else if (mul_ce) begin
            tag_r[0] <= {grant_any_s, MUL_ID_W_MAX'(grant_idx_s)};
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_r[s] <= tag_r[s-1];
            end
        end else begin
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_r[s] <= tag_r[s];
            end
        end
    end

    assign bus.res_valid = tag_r[MUL_LAT-1].valid;
    assign bus.res_id    = tag_r[MUL_LAT-1].id[ID_W-1:0];
    assign bus.res_data  = mul_dout;

    assign consume_s = bus.res_valid & bus.res_ready;

    // Count of valid tags: +1 per issue, -1 per consumed result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({grant_any_s, consume_s})
                2'b10:   inflight <= inflight + INF_W'(1);
                2'b01:   inflight <= inflight - INF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_fracnet_mul_share_arb.sv
// ---------------------------------------------------------------------------
// tb_fracnet_mul_share_arb
// Drives directed scenarios into fracnet_mul_share_arb with a behavioural
// multiplier attached, checks every cycle against a queue-based model of the
// arbitration/latency rules, and pins the model with hand-computed values.
// ---------------------------------------------------------------------------
module tb_fracnet_mul_share_arb;
    import fracnet_mul_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mul_ce;
    logic [15:0] mul_din0;
    logic [7:0]  mul_din1;
    logic [23:0] mul_dout;
    logic [2:0]  inflight;

    int checks = 0;
    int errors = 0;

    fracnet_mul_share_arb_if #(.N_REQ(N), .ID_W(2)) bus ();

    fracnet_mul_share_arb #(.N_REQ(N), .MUL_LAT(LAT), .ID_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mul_ce   (mul_ce),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .inflight (inflight)
    );

    always #5 clk = ~clk;

    // External multiplier: 3 enabled register stages, never reset.
    logic signed [23:0] mp [3];
    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= $signed(mul_din0) * $signed({1'b0, mul_din1});
            mp[1] <= mp[0];
            mp[2] <= mp[1];
        end
    end
    assign mul_dout = mp[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        int          id;
        logic [23:0] prod;
    } ent_t;

    ent_t        pipe_q[$];      // front = newest issue, back = result tail
    ent_t        tail, nx, empty_e;
    int          m_ptr;
    bit          m_ok = 1'b0;
    bit          exp_ce;
    int          g, cnt, pa, pb, p;
    logic [N-1:0] exp_rdy;
    int          cons_id_q[$];
    logic [23:0] cons_d_q[$];

    always @(negedge clk) begin
        if (!m_ok) begin
            if (!reset) begin
                empty_e = '{v: 1'b0, id: 0, prod: 24'd0};
                pipe_q.delete();
                for (int s = 0; s < LAT; s++) pipe_q.push_back(empty_e);
                m_ptr = 0;
                m_ok  = 1'b1;
            end
        end else begin
            tail   = pipe_q[LAT-1];
            exp_ce = !(tail.v && !bus.res_ready);
            g = -1;
            if (reset && exp_ce) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            cnt = 0;
            foreach (pipe_q[s]) if (pipe_q[s].v) cnt++;

            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("mul_ce", 64'(mul_ce), 64'(exp_ce));
            chk("res_valid", 64'(bus.res_valid), 64'(tail.v));
            chk("inflight", 64'(inflight), 64'(cnt));
            if (tail.v) begin
                chk("res_id", 64'(bus.res_id), 64'(tail.id));
                chk("res_data", 64'(bus.res_data), 64'(tail.prod));
            end
            if (g >= 0) begin
                chk("mul_din0", 64'(mul_din0), 64'(bus.req_a[g*16 +: 16]));
                chk("mul_din1", 64'(mul_din1), 64'(bus.req_b[g*8 +: 8]));
            end
            if (bus.res_valid && bus.res_ready) begin
                cons_id_q.push_back(int'(bus.res_id));
                cons_d_q.push_back(bus.res_data);
            end

            if (!reset) begin
                empty_e = '{v: 1'b0, id: 0, prod: 24'd0};
                pipe_q.delete();
                for (int s = 0; s < LAT; s++) pipe_q.push_back(empty_e);
                m_ptr = 0;
            end else if (exp_ce) begin
                nx = '{v: 1'b0, id: 0, prod: 24'd0};
                if (g >= 0) begin
                    pa = int'($signed(bus.req_a[g*16 +: 16]));
                    pb = int'(bus.req_b[g*8 +: 8]);
                    p  = pa * pb;
                    nx = '{v: 1'b1, id: g, prod: p[23:0]};
                    m_ptr = (g + 1) % N;
                end
                pipe_q.push_front(nx);
                void'(pipe_q.pop_back());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        bus.req_a[i*16 +: 16] = 16'(a);
        bus.req_b[i*8 +: 8]   = 8'(b);
    endtask

    task automatic issue(input int i, input int a, input int b);
        bit done;
        done = 1'b0;
        set_req(i, a, b);
        bus.req_valid    = '0;
        bus.req_valid[i] = 1'b1;
        for (int w = 0; w < 40 && !done; w++) begin
            @(negedge clk);
            if (bus.req_ready[i]) done = 1'b1;
            tick();
        end
        chk("issue_handshake", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          base, pa_k, pb_k, pk;
    logic [23:0] exp_p [6];
    int          exp_id [6];

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        reset         = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        // Single request from requester 2: -3 * 200 = -600.
        set_req(2, -3, 200);
        bus.req_valid = 4'b0100;
        @(negedge clk); chk("t1_grant", 64'(bus.req_ready), 64'h4);
        tick(); bus.req_valid = '0;
        @(negedge clk); chk("t1_lat1", 64'(bus.res_valid), 64'd0);
        tick();
        @(negedge clk); chk("t1_lat2", 64'(bus.res_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("t1_valid", 64'(bus.res_valid), 64'd1);
        chk("t1_id", 64'(bus.res_id), 64'd2);
        chk("t1_data", 64'(bus.res_data), 64'hFFFDA8);
        tick();

        // Extremes back to back from requester 0.
        set_req(0, 32767, 255);
        bus.req_valid = 4'b0001;
        @(negedge clk); chk("t2_grant_a", 64'(bus.req_ready), 64'h1);
        tick(); set_req(0, -32768, 255);
        @(negedge clk); chk("t2_grant_b", 64'(bus.req_ready), 64'h1);
        tick(); bus.req_valid = '0;
        @(negedge clk); chk("t2_inflight", 64'(inflight), 64'd2);
        tick();
        @(negedge clk);
        chk("t2_max_data", 64'(bus.res_data), 64'h7F7F01);
        chk("t2_max_id", 64'(bus.res_id), 64'd0);
        tick();
        @(negedge clk);
        chk("t2_min_valid", 64'(bus.res_valid), 64'd1);
        chk("t2_min_data", 64'(bus.res_data), 64'h808000);
        repeat (3) tick();

        // Backpressure: 6 issues, res_ready low for 4 cycles.
        for (int k = 0; k < 6; k++) begin
            pa_k = k * 1000 - 2500;
            pb_k = k * 40 + 7;
            pk   = pa_k * pb_k;
            exp_p[k]  = pk[23:0];
            exp_id[k] = k % 4;
        end
        base = cons_id_q.size();
        fork
            begin
                for (int k = 0; k < 6; k++) issue(k % 4, k * 1000 - 2500, k * 40 + 7);
                bus.req_valid = '0;
            end
            begin
                repeat (3) tick();
                bus.res_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    if (c > 0) tick();
                    @(negedge clk);
                    chk("t4_stall_ce", 64'(mul_ce), 64'd0);
                    chk("t4_stall_rdy", 64'(bus.req_ready), 64'd0);
                    chk("t4_frozen_id", 64'(bus.res_id), 64'(exp_id[0]));
                    chk("t4_frozen_data", 64'(bus.res_data), 64'(exp_p[0]));
                end
                tick();
                bus.res_ready = 1'b1;
            end
        join
        repeat (5) tick();
        chk("t4_count", 64'(cons_id_q.size() - base), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < cons_id_q.size()) begin
                chk("t4_order_id", 64'(cons_id_q[base + k]), 64'(exp_id[k]));
                chk("t4_order_data", 64'(cons_d_q[base + k]), 64'(exp_p[k]));
            end
        end

        // Bubble squeeze with res_ready low: 1234 * 10 = 12340.
        bus.res_ready = 1'b0;
        issue(1, 1234, 10);
        bus.req_valid = '0;
        @(negedge clk); chk("t5_ce_1", 64'(mul_ce), 64'd1);
        tick();
        @(negedge clk); chk("t5_ce_2", 64'(mul_ce), 64'd1);
        tick();
        @(negedge clk);
        chk("t5_tail_valid", 64'(bus.res_valid), 64'd1);
        chk("t5_tail_ce", 64'(mul_ce), 64'd0);
        chk("t5_tail_data", 64'(bus.res_data), 64'd12340);
        tick();
        @(negedge clk);
        chk("t5_hold_ce", 64'(mul_ce), 64'd0);
        chk("t5_hold_inflight", 64'(inflight), 64'd1);
        tick(); bus.res_ready = 1'b1;
        tick();
        @(negedge clk); chk("t5_drained", 64'(inflight), 64'd0);
        tick();

        // Reset mid-flight: three ops in the pipe are dropped.
        issue(3, 777, 9);
        issue(2, -555, 33);
        issue(1, 4321, 2);
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        reset         = 1'b0;
        base          = cons_id_q.size();
        tick();

        // Fairness right after reset: all four requesters valid.
        reset = 1'b1;
        bus.res_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, i * 1111 - 2000, i * 60 + 3);
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("fair_grant", 64'(bus.req_ready), 64'(1 << (c % 4)));
            if (c < 3) begin
                chk("t6_no_stale", 64'(bus.res_valid), 64'd0);
                if (c == 0) chk("t6_inflight", 64'(inflight), 64'd0);
            end else begin
                chk("fair_res_valid", 64'(bus.res_valid), 64'd1);
                chk("fair_res_id", 64'(bus.res_id), 64'((c - 3) % 4));
                chk("fair_inflight", 64'(inflight), 64'd3);
            end
            tick();
        end
        bus.req_valid = '0;
        chk("t6_first_after_reset", 64'(cons_id_q.size() > base), 64'd1);
        if (cons_id_q.size() > base) begin
            chk("t6_first_id", 64'(cons_id_q[base]), 64'd0);
            chk("t6_first_data", 64'(cons_d_q[base]), 64'(24'hFFE890));
        end
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
